seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised Mealy serial-pattern detector, the next generation of the fixed 4-state "1011" detector. It watches a 1-bit serial stream qualified by `in_valid` and compares it against a runtime-programmable pattern of `PAT_LEN` bits. It supports overlapping and non-overlapping detection, selectable at runtime, and keeps a saturating match counter. It sits directly on a serial input bit-stream and drives a same-cycle match flag to downstream control logic.

## Interface
Parameters:
- `PAT_LEN`, 4: pattern length in bits; legal range 2..32.
- `PAT_DEFAULT`, 4'b1011: pattern loaded at reset. MSB is the first bit received.
- `OVERLAP_DEFAULT`, 1: detection mode at reset; 1 = overlapping.
- `CNT_W`, 8: match-counter width.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `x` input 1: serial data bit.
- `in_valid` input 1: `x` is sampled only when high.
- `cfg_we` input 1: one-cycle strobe that loads `cfg_pattern`/`cfg_overlap` and flushes the window.
- `cfg_pattern` input PAT_LEN: new pattern; MSB is the oldest bit.
- `cfg_overlap` input 1: new mode.
- `cnt_clr` input 1: clears `match_count`.
- `z` output 1: Mealy match flag, combinational.
- `match_count` output CNT_W: number of matches, saturating.

## Operation
Internal state:
- `win[PAT_LEN-2:0]`: last PAT_LEN-1 accepted bits; LSB is the newest.
- `fill`: number of valid bits currently held in `win`. It is $clog2(PAT_LEN) wide and saturates at PAT_LEN-1.
- Registered `pat` and `ovl`.

Reset (`reset`=1 at a rising edge):
- `win`=0, `fill`=0.
- `pat`=PAT_DEFAULT, `ovl`=OVERLAP_DEFAULT.
- `match_count`=0.
- `z` therefore reads 0 after reset.

Match condition:
- `z` = `in_valid` & !`cfg_we` & (`fill`==PAT_LEN-1) & ({`win`, `x`} == `pat`).

Accepted bit (`in_valid`=1, `cfg_we`=0):
- `win` <= {`win`[PAT_LEN-3:0], `x`}.
- If `z`=1 and `ovl`=0: `fill` <= 0, so the matched bits are not reused.
- Otherwise: `fill` <= min(`fill`+1, PAT_LEN-1).

Idle cycles (`in_valid`=0) leave all state unchanged; gaps in the stream are transparent.

Configuration write (`cfg_we`=1):
- `pat` and `ovl` are loaded; `win` and `fill` are cleared.
- A simultaneous `x` is discarded and `z`=0.
- `match_count` is untouched.

Counter:
- On a rising edge with `z`=1, `match_count` increments.
- It saturates at 2^CNT_W-1 and never wraps.
- `cnt_clr` has priority over a simultaneous match: the result is 0.

Priority order: `reset` > `cfg_we` > data path; independently, `cnt_clr` > increment.

## Timing
- `z` has zero latency: it is valid in the same cycle as the last pattern bit on `x`. There is no registered output.
- `match_count` reflects a match one cycle after `z` is asserted.
- First possible match: on the PAT_LEN-th accepted bit after reset or `cfg_we`.
- Overlapping mode: back-to-back matches can occur as often as every accepted bit (e.g. pattern 1111 on a run of 1s).
- Non-overlapping mode: matches are at least PAT_LEN accepted bits apart.
- `reset` asserted mid-pattern discards the partial match. The cycle `reset` is asserted, `z` may still be 1 combinationally; the counter does not increment on that edge.

## Configuration
- `SEQ_DET_CNT_EN` defined: `match_count` and `cnt_clr` behave as above.
- `SEQ_DET_CNT_EN` undefined:
  - The counter logic is not built.
  - `match_count` is tied to 0 and `cnt_clr` is ignored.
  - Ports remain, so the module interface is unchanged.
  - `z` behaviour is identical in both builds.

## Structure
- Package `seq_det_pkg` holds:
  - default constants: `SEQ_DET_PAT_LEN_DEF`=4, `SEQ_DET_PAT_DEF`=4'b1011, `SEQ_DET_CNT_W_DEF`=8;
  - the `fill`-width function.
- One sub-module, `seq_det_sat_cnt`: a CNT_W saturating counter with clear-priority. It is instantiated only under `SEQ_DET_CNT_EN`.
- Window, fill and match logic stay in the top level.

## Test plan
- Overlapping default: reset, then stream 1,0,1,1,0,1,1 with `in_valid`=1.
  - `z`=1 on bits 4 and 7 only.
  - `match_count`=2.
- Non-overlapping: `cfg_we` with `cfg_pattern`=4'b1011 and `cfg_overlap`=0, then the same stream.
  - `z`=1 on bit 4 only.
  - `match_count` rises by 1.
- Gaps: stream 1,0,1,1 with `in_valid` low for 3 cycles between each bit.
  - `z`=1 only in the cycle the final 1 is valid.
  - `z`=0 while `in_valid`=0 even though `x`=1.
- Reprogram mid-stream: send 1,0,1, then assert `cfg_we` (pattern 4'b0110) together with `x`=1.
  - No match is produced.
  - 0,1,1,0 then gives `z`=1 on the 4th bit.
- Saturation and clear (CNT_W=2): 5 matches of pattern 11 in overlapping mode.
  - `match_count` holds at 3.
  - `cnt_clr` asserted in the same cycle as a match gives 0.
- Macro off: rerun the first scenario without `SEQ_DET_CNT_EN`.
  - `z` is identical.
  - `match_count` stays 0 throughout.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and the fill-counter width helper for seq_detector_param
package seq_det_pkg;
  localparam int SEQ_DET_PAT_LEN_DEF = 4;
  localparam logic [3:0] SEQ_DET_PAT_DEF = 4'b1011;
  localparam int SEQ_DET_CNT_W_DEF = 8;
  function automatic int seq_det_fill_w(input int pat_len);
    return $clog2(pat_len);
  endfunction
endpackage

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt: saturating up-counter, clear beats increment
module seq_det_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: programmable Mealy pattern detector; SEQ_DET_CNT_EN builds the match counter
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN         = SEQ_DET_PAT_LEN_DEF,
  parameter logic [PAT_LEN-1:0] PAT_DEFAULT     = PAT_LEN'(SEQ_DET_PAT_DEF),
  parameter logic               OVERLAP_DEFAULT = 1'b1,
  parameter int                 CNT_W           = SEQ_DET_CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               in_valid,
  input  logic               cfg_we,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count
);
  localparam int FW = seq_det_fill_w(PAT_LEN);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);
  logic [PAT_LEN-2:0] win;
  logic [FW-1:0]      fill;
  logic [PAT_LEN-1:0] pat;
  logic [PAT_LEN-1:0] cat;
  logic               ovl;
  assign cat = {win, x};
  assign z = in_valid & ~cfg_we & (fill == FULL) & (cat == pat);
  // non-overlapping mode restarts the fill so matched bits cannot be reused
  always_ff @(posedge clk)
    if (reset) begin
      win  <= '0;
      fill <= '0;
      pat  <= PAT_DEFAULT;
      ovl  <= OVERLAP_DEFAULT;
    end else if (cfg_we) begin
      win  <= '0;
      fill <= '0;
      pat  <= cfg_pattern;
      ovl  <= cfg_overlap;
    end else if (in_valid) begin
      win  <= cat[PAT_LEN-2:0];
      fill <= (z && !ovl) ? '0 : (fill == FULL) ? fill : fill + 1'b1;
    end
`ifdef SEQ_DET_CNT_EN
  seq_det_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (z),
    .cnt  (match_count)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: table-driven scoreboard bench for seq_detector_param
module tb_seq_detector_param;
`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  typedef struct {
    logic       rst, v, x, we;
    logic [3:0] pat;
    logic       ovl, clr, ez;
    int         ec;
  } vec_t;
  typedef struct {
    logic  z;
    int    c;
    string nm;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset, x, in_valid, cfg_we, cfg_overlap, cnt_clr, z;
  logic [3:0] cfg_pattern;
  logic [7:0] match_count;
  logic       s_reset, s_x, s_valid, s_clr, s_z;
  logic [1:0] s_count;
  vec_t       vt[$];
  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  always #5 clk = ~clk;
  seq_detector_param u_dut (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .z(z), .match_count(match_count)
  );
  seq_detector_param #(.PAT_LEN(2), .PAT_DEFAULT(2'b11), .OVERLAP_DEFAULT(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(s_reset), .x(s_x), .in_valid(s_valid), .cfg_we(1'b0),
    .cfg_pattern(2'b00), .cfg_overlap(1'b0), .cnt_clr(s_clr),
    .z(s_z), .match_count(s_count)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic add(input logic rst, v, xb, we, input logic [3:0] pat,
                     input logic ovl, clr, ez, input int ec);
    vt.push_back('{rst, v, xb, we, pat, ovl, clr, ez, ec});
  endtask
  task automatic drive_main(input vec_t t, input int i);
    exp_t e;
    @(posedge clk);
    #1;
    reset = t.rst; in_valid = t.v; x = t.x; cfg_we = t.we;
    cfg_pattern = t.pat; cfg_overlap = t.ovl; cnt_clr = t.clr;
    sb.push_back('{t.ez, CNT_EN ? t.ec : 0, $sformatf("v%0d", i)});
    #3;
    e = sb.pop_front();
    chk({e.nm, "_z"}, 32'(z), 32'(e.z));
    chk({e.nm, "_cnt"}, 32'(match_count), 32'(e.c));
  endtask
  task automatic sat_step(input string nm, input logic v, xb, clr, ez, input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    s_reset = 1'b0; s_valid = v; s_x = xb; s_clr = clr;
    sb.push_back('{ez, CNT_EN ? ec : 0, nm});
    #3;
    e = sb.pop_front();
    chk({e.nm, "_z"}, 32'(s_z), 32'(e.z));
    chk({e.nm, "_cnt"}, 32'(s_count), 32'(e.c));
  endtask
  initial begin
    reset = 1'b1; in_valid = 1'b0; x = 1'b0; cfg_we = 1'b0;
    cfg_pattern = 4'b0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    s_reset = 1'b1; s_valid = 1'b0; s_x = 1'b0; s_clr = 1'b0;
    repeat (2) @(posedge clk);
    // reset state
    add(1,0,0,0,4'h0,0,0,0,0);
    // overlapping default, stream 1011011
    add(0,1,1,0,4'h0,0,0,0,0); add(0,1,0,0,4'h0,0,0,0,0); add(0,1,1,0,4'h0,0,0,0,0);
    add(0,1,1,0,4'h0,0,0,1,0); add(0,1,0,0,4'h0,0,0,0,1); add(0,1,1,0,4'h0,0,0,0,1);
    add(0,1,1,0,4'h0,0,0,1,1); add(0,0,1,0,4'h0,0,0,0,2);
    // non-overlapping, x during cfg_we is discarded
    add(0,1,1,1,4'b1011,0,0,0,2);
    add(0,1,1,0,4'h0,0,0,0,2); add(0,1,0,0,4'h0,0,0,0,2); add(0,1,1,0,4'h0,0,0,0,2);
    add(0,1,1,0,4'h0,0,0,1,2); add(0,1,0,0,4'h0,0,0,0,3); add(0,1,1,0,4'h0,0,0,0,3);
    add(0,1,1,0,4'h0,0,0,0,3); add(0,0,1,0,4'h0,0,0,0,3);
    // gaps with x=1 while invalid
    add(0,0,0,1,4'b1011,1,0,0,3);
    add(0,1,1,0,4'h0,0,0,0,3);
    for (int k = 0; k < 3; k++) add(0,0,1,0,4'h0,0,0,0,3);
    add(0,1,0,0,4'h0,0,0,0,3);
    for (int k = 0; k < 3; k++) add(0,0,1,0,4'h0,0,0,0,3);
    add(0,1,1,0,4'h0,0,0,0,3);
    for (int k = 0; k < 3; k++) add(0,0,1,0,4'h0,0,0,0,3);
    add(0,1,1,0,4'h0,0,0,1,3); add(0,0,1,0,4'h0,0,0,0,4);
    // reprogram mid-stream: the cfg_we bit would otherwise complete 1011
    add(0,1,1,0,4'h0,0,0,0,4); add(0,1,0,0,4'h0,0,0,0,4); add(0,1,1,0,4'h0,0,0,0,4);
    add(0,1,1,1,4'b0110,1,0,0,4);
    add(0,1,0,0,4'h0,0,0,0,4); add(0,1,1,0,4'h0,0,0,0,4); add(0,1,1,0,4'h0,0,0,0,4);
    add(0,1,0,0,4'h0,0,0,1,4); add(0,0,0,0,4'h0,0,0,0,5);
    // reset during a combinational match: no increment, count cleared
    add(0,1,0,0,4'h0,0,0,0,5); add(0,1,1,0,4'h0,0,0,0,5); add(0,1,1,0,4'h0,0,0,0,5);
    add(1,1,0,0,4'h0,0,0,1,5); add(0,0,0,0,4'h0,0,0,0,0);
    // cnt_clr against a simultaneous match, then on its own
    add(0,1,1,0,4'h0,0,0,0,0); add(0,1,0,0,4'h0,0,0,0,0); add(0,1,1,0,4'h0,0,0,0,0);
    add(0,1,1,0,4'h0,0,1,1,0); add(0,0,0,0,4'h0,0,0,0,0);
    add(0,1,0,0,4'h0,0,0,0,0); add(0,1,1,0,4'h0,0,0,0,0); add(0,1,1,0,4'h0,0,0,1,0);
    add(0,0,0,0,4'h0,0,0,0,1); add(0,0,0,0,4'h0,0,1,0,1); add(0,0,0,0,4'h0,0,0,0,0);
    for (int i = 0; i < vt.size(); i++) drive_main(vt[i], i);
    in_valid = 1'b0;
    // 2-bit pattern 11 on a 2-bit counter: saturate at 3, then clear on a match
    sat_step("sat0", 1, 1, 0, 0, 0);
    sat_step("sat1", 1, 1, 0, 1, 0);
    sat_step("sat2", 1, 1, 0, 1, 1);
    sat_step("sat3", 1, 1, 0, 1, 2);
    sat_step("sat4", 1, 1, 0, 1, 3);
    sat_step("sat5", 1, 1, 0, 1, 3);
    sat_step("sat_hold", 0, 1, 0, 0, 3);
    sat_step("sat_clr", 1, 1, 1, 1, 3);
    sat_step("sat_after", 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
